rf_read_arbiter: RTL and testbench
==================================

Name: rf_read_arbiter

Overview:
- Shares one 32:1 register-file read mux between NUM_REQ requesters. One read is serviced at a time.
- Arbitration is round-robin. The block drives the mux select from the granted address, registers the mux output, and returns it with the requester ID.
- Sits between the register-file read mux and the units needing read access (decode, debug port, etc.).

Parameters:
N, 32, data width (matches the mux datapath width)
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 5, register address width (fixed by the 32-input mux)
ID_W, 2, width of resp_id; must equal $clog2(NUM_REQ)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  per-requester read request
req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
req_ready  output  NUM_REQ  one-hot grant/accept strobe
mux_select  output  ADDR_W  select to the external 32:1 mux
mux_out  input  N  data returned by the external mux
resp_valid  output  1  response data valid
resp_data  output  N  captured read data
resp_id  output  ID_W  index of the requester owning resp_data
resp_ready  input  1  consumer accepts the response

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high.
- Reset values: state=IDLE, rr pointer=0, mux_select=0, resp_valid=0, resp_data=0, resp_id=0, req_ready=0. Reset has priority over every other event.
- Reset mid-transaction: the in-flight read is dropped with no response. The next grant starts from requester 0.
- FSM states: IDLE, READ, RESP.
- IDLE:
  - Search req_valid starting at the rr pointer, wrapping modulo NUM_REQ; the first asserted bit wins.
  - req_ready[winner]=1 combinationally in this cycle only; all other bits stay 0.
  - On the clock edge: mux_select <= req_addr of the winner; resp_id <= winner; pointer <= (winner+1) mod NUM_REQ; go to READ.
  - If no request is pending, stay in IDLE; mux_select holds its last value.
- READ:
  - mux_select is stable.
  - On the clock edge: resp_data <= mux_out, resp_valid <= 1; go to RESP.
- RESP:
  - resp_valid=1; resp_data, resp_id and mux_select are held.
  - When resp_ready=1: resp_valid <= 0 and go to IDLE.
  - resp_ready=0 stalls indefinitely; no new grant is issued while in RESP.
- req_ready is 0 in READ and RESP, regardless of req_valid.
- Latency and throughput:
  - Grant-cycle edge to resp_valid high: 2 edges.
  - Best-case throughput: one read per 3 cycles (IDLE, READ, RESP with resp_ready=1).
- Requester rules:
  - A requester holds req_valid and req_addr stable until it sees req_ready.
  - Deasserting req_valid before the grant is legal; that requester is simply not considered.
  - Address changes after the grant are ignored, because the address was captured.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. No requester waits more than NUM_REQ grants.
- Simultaneous events: a resp_ready handshake and a new req_valid in the same cycle → the request is granted in the following IDLE cycle, not the same cycle.
- Address 0 needs no special handling; the block returns whatever mux_out presents.

Decomposition:
- Package rf_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, READ, RESP} rf_arb_state_t;
  - localparam ADDR_W=5.
- Sub-module rr_priority_picker (combinational).
  - Inputs: req vector, pointer.
  - Outputs: found, winner index.
  - Implemented as a rotate, find-first, un-rotate. Reusable by other arbiters.

Test Plan:
1. Reset: hold rst=1 with all req_valid=1 → req_ready=0, resp_valid=0, mux_select=0, resp_data=0. Release rst → first grant goes to req 0.
2. Single read: req_valid=4'b0100, req_addr[2]=5'd17, external mux returns 32'hDEAD_0017 for select 17 → req_ready=4'b0100 for exactly 1 cycle. Then mux_select=17, and 2 edges later resp_valid=1, resp_data=32'hDEAD_0017, resp_id=2.
3. Round-robin: all four requesters valid continuously with resp_ready=1 → resp_id sequence 0,1,2,3,0,1; a new resp_valid rises every 3 cycles.
4. Backpressure: hold resp_ready=0 for 10 cycles with other requests pending → resp_valid, resp_data, resp_id and mux_select stay stable and req_ready stays 0. One cycle with resp_ready=1 returns the FSM to IDLE; the next grant goes to (previous winner+1).
5. Mid-operation reset: assert rst in READ → next cycle state is IDLE, resp_valid=0, pointer=0; no response for the dropped read is ever produced.
6. Address change after grant: req 1 is granted with addr 5, then drives addr 9 → resp_data equals mux data for select 5.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file read arbiter.
// The address width is fixed by the 32-input read mux.
package rf_arb_pkg;

  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RESP
  } rf_arb_state_t;

endpackage : rf_arb_pkg

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker. It searches the request vector starting at
// ptr_i and wraps modulo NUM_REQ. The first set bit wins.
// The search is done in three steps: rotate the vector so that ptr_i lands
// on bit 0, find the lowest set bit, then add ptr_i back.
// The block is purely combinational and can be reused by other arbiters.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   winner_o
);

  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rotated;
  logic [IDX_W-1:0]   offset;
  logic               hit;
  logic [IDX_W:0]     sum;

  // Rotate the request vector so that the current pointer sits at bit 0.
  always_comb begin
    rotated = '0;
    for (int p = 0; p < NUM_REQ; p++) begin
      if (ptr_i == IDX_W'(p)) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          rotated[i] = req_i[(i + p) % NUM_REQ];
        end
      end
    end
  end

  // Find the lowest set bit of the rotated vector.
  // The loop runs downwards so that the lowest index is written last.
  always_comb begin
    hit    = 1'b0;
    offset = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        hit    = 1'b1;
        offset = IDX_W'(i);
      end
    end
  end

  // Undo the rotation with a modulo-NUM_REQ add. The extra bit keeps the
  // carry for requester counts that are not a power of two.
  always_comb begin
    sum = {1'b0, offset} + {1'b0, ptr_i};
    if (sum >= NUM_REQ_W) begin
      sum = sum - NUM_REQ_W;
    end
    winner_o = sum[IDX_W-1:0];
    found_o  = hit;
  end

endmodule : rr_priority_picker

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter that shares one 32:1 register-file read mux between
// NUM_REQ requesters. Each read takes three phases:
//   IDLE - a grant is issued,
//   READ - the mux settles on the captured address,
//   RESP - the registered data is held until the consumer accepts it.
// Only one read is in flight at a time.
module rf_read_arbiter
  import rf_arb_pkg::*;
#(
  parameter int N       = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         mux_select,
  input  logic [N-1:0]              mux_out,
  output logic                      resp_valid,
  output logic [N-1:0]              resp_data,
  output logic [ID_W-1:0]           resp_id,
  input  logic                      resp_ready
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  rf_arb_state_t state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0] sel_q, sel_d;
  logic [N-1:0]      data_q, data_d;
  logic              valid_q, valid_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic               found;
  logic [ID_W-1:0]    winner;
  logic [ADDR_W-1:0]  winnerAddr;
  logic [NUM_REQ-1:0] winnerOneHot;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_picker (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .found_o  (found),
    .winner_o (winner)
  );

  // Decode the winner index into a one-hot strobe and pick its address.
  always_comb begin
    winnerOneHot = '0;
    winnerAddr   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        winnerOneHot[i] = 1'b1;
        winnerAddr      = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Next-state logic and the combinational grant strobe.
  // The grant is only raised in IDLE. It is also masked while reset is
  // asserted, so no requester sees an accept that the next edge discards.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    data_d    = data_q;
    valid_d   = valid_q;
    id_d      = id_q;
    req_ready = '0;

    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready = winnerOneHot;
          sel_d     = winnerAddr;
          id_d      = winner;
          ptr_d     = (winner == LAST_ID) ? '0 : winner + ID_W'(1);
          state_d   = READ;
        end
      end
      READ: begin
        data_d  = mux_out;
        valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rst) begin
      req_ready = '0;
    end
  end

  // State and datapath registers. Reset drops any in-flight read and
  // restarts the round-robin search from requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  assign mux_select = sel_q;
  assign resp_valid = valid_q;
  assign resp_data  = data_q;
  assign resp_id    = id_q;

endmodule : rf_read_arbiter

// File: tb/tb_rf_read_arbiter.sv
// Self-checking bench for rf_read_arbiter. The external read mux is
// modelled as a random lookup table. Expected grants and responses come
// from a transaction-level round-robin model.
module tb_rf_read_arbiter;
  import rf_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NR-1:0]         req_valid;
  logic [NR*ADDR_W-1:0]  req_addr;
  logic [NR-1:0]         req_ready;
  logic [ADDR_W-1:0]     mux_select;
  logic [DW-1:0]         mux_out;
  logic                  resp_valid;
  logic [DW-1:0]         resp_data;
  logic [IW-1:0]         resp_id;
  logic                  resp_ready;

  logic [DW-1:0] memData [32];
  int checks   = 0;
  int failures = 0;
  int modelPtr = 0;

  always #5 clk = ~clk;

  assign mux_out = memData[mux_select];

  rf_read_arbiter #(
    .N       (DW),
    .NUM_REQ (NR),
    .ID_W    (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .mux_select (mux_select),
    .mux_out    (mux_out),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready)
  );

  // Round-robin rule: scan from ptr upwards, wrapping; the first valid wins.
  function automatic int pickWinner(logic [NR-1:0] v, int ptr);
    for (int k = 0; k < NR; k++) begin
      if (v[IW'((ptr + k) % NR)]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] oneHot(int w);
    logic [NR-1:0] r;
    r = '0;
    if (w >= 0) r[IW'(w)] = 1'b1;
    return r;
  endfunction

  task automatic setAddr(int i, logic [ADDR_W-1:0] a);
    req_addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  function automatic logic [ADDR_W-1:0] getAddr(int i);
    return req_addr[i*ADDR_W +: ADDR_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    repeat (2) tick();
    rst      = 1'b0;
    modelPtr = 0;
  endtask

  // Reset values with every requester asserting, then the first grant.
  task automatic test_reset();
    logic [NR-1:0] exp;
    rst        = 1'b1;
    req_valid  = '1;
    resp_ready = 1'b0;
    for (int i = 0; i < NR; i++) setAddr(i, ADDR_W'($urandom_range(0, 31)));
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (req_ready !== '0) begin
      failures++; $display("[TB] FAIL reset_req_ready: got %b expected 0", req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid);
    end
    checks++;
    if (mux_select !== '0) begin
      failures++; $display("[TB] FAIL reset_mux_select: got %0d expected 0", mux_select);
    end
    checks++;
    if (resp_data !== '0) begin
      failures++; $display("[TB] FAIL reset_resp_data: got %h expected 0", resp_data);
    end
    checks++;
    if (resp_id !== '0) begin
      failures++; $display("[TB] FAIL reset_resp_id: got %0d expected 0", resp_id);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    modelPtr = 0;
    @(negedge clk);
    exp = oneHot(pickWinner(req_valid, modelPtr));
    checks++;
    if (req_ready !== exp) begin
      failures++; $display("[TB] FAIL reset_first_grant: got %b expected %b", req_ready, exp);
    end
  endtask

  // A single read from requester 2 at address 17.
  task automatic test_single_read();
    logic [NR-1:0] exp;
    doReset();
    req_valid = 4'b0100;
    setAddr(2, 5'd17);
    @(negedge clk);
    exp = oneHot(pickWinner(req_valid, modelPtr));
    checks++;
    if (req_ready !== exp) begin
      failures++; $display("[TB] FAIL single_grant: got %b expected %b", req_ready, exp);
    end
    modelPtr = 3;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || mux_select !== 5'd17 || resp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_read_phase: ready=%b sel=%0d valid=%b expected ready=0 sel=17 valid=0",
               req_ready, mux_select, resp_valid);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'hDEAD_0017 || resp_id !== 2'd2) begin
      failures++;
      $display("[TB] FAIL single_resp: valid=%b data=%h id=%0d expected valid=1 data=dead0017 id=2",
               resp_valid, resp_data, resp_id);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL single_resp_drop: got %b expected 0", resp_valid);
    end
  endtask

  // All requesters valid with an always-ready consumer: grants rotate and a
  // response rises every three cycles.
  task automatic test_round_robin();
    int idQ[$];
    logic [ADDR_W-1:0] addrQ[$];
    int lastRise;
    int rises;
    int w;
    logic prevValid;
    logic [NR-1:0] exp;
    lastRise  = -1;
    rises     = 0;
    prevValid = 1'b0;
    doReset();
    resp_ready = 1'b1;
    req_valid  = '1;
    for (int i = 0; i < NR; i++) setAddr(i, ADDR_W'($urandom_range(0, 31)));
    for (int cyc = 0; cyc < 18; cyc++) begin
      @(negedge clk);
      w = -1;
      if (req_ready !== '0) begin
        w   = pickWinner(req_valid, modelPtr);
        exp = oneHot(w);
        checks++;
        if (req_ready !== exp) begin
          failures++; $display("[TB] FAIL rr_grant: got %b expected %b", req_ready, exp);
        end
        idQ.push_back(w);
        addrQ.push_back(getAddr(w));
        modelPtr = (w + 1) % NR;
      end
      if (resp_valid === 1'b1 && prevValid === 1'b0) begin
        if (rises > 0) begin
          checks++;
          if (cyc - lastRise != 3) begin
            failures++; $display("[TB] FAIL rr_spacing: got %0d cycles expected 3", cyc - lastRise);
          end
        end
        checks++;
        if (idQ.size() == 0) begin
          failures++; $display("[TB] FAIL rr_unexpected_resp: got id %0d expected no response", resp_id);
        end else begin
          if (resp_id !== IW'(idQ[0]) || resp_data !== memData[addrQ[0]]) begin
            failures++;
            $display("[TB] FAIL rr_resp: got id=%0d data=%h expected id=%0d data=%h",
                     resp_id, resp_data, idQ[0], memData[addrQ[0]]);
          end
          void'(idQ.pop_front());
          void'(addrQ.pop_front());
        end
        lastRise = cyc;
        rises++;
      end
      prevValid = resp_valid;
      @(posedge clk);
      #1;
      if (w >= 0) setAddr(w, ADDR_W'($urandom_range(0, 31)));
    end
    checks++;
    if (rises != 6) begin
      failures++; $display("[TB] FAIL rr_resp_count: got %0d expected 6", rises);
    end
    resp_ready = 1'b0;
  endtask

  // A stalled consumer holds the response; afterwards the next requester wins.
  task automatic test_backpressure();
    int w;
    logic [ADDR_W-1:0] gAddr;
    logic [NR-1:0] exp;
    doReset();
    req_valid = '1;
    for (int i = 0; i < NR; i++) setAddr(i, ADDR_W'($urandom_range(0, 31)));
    @(negedge clk);
    w     = pickWinner(req_valid, modelPtr);
    gAddr = getAddr(w);
    exp   = oneHot(w);
    checks++;
    if (req_ready !== exp) begin
      failures++; $display("[TB] FAIL bp_grant: got %b expected %b", req_ready, exp);
    end
    modelPtr = (w + 1) % NR;
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== memData[gAddr] || resp_id !== IW'(w) ||
          mux_select !== gAddr || req_ready !== '0) begin
        failures++;
        $display("[TB] FAIL bp_hold: valid=%b data=%h id=%0d sel=%0d ready=%b expected valid=1 data=%h id=%0d sel=%0d ready=0",
                 resp_valid, resp_data, resp_id, mux_select, req_ready, memData[gAddr], w, gAddr);
      end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    @(negedge clk);
    exp = oneHot(pickWinner(req_valid, modelPtr));
    checks++;
    if (req_ready !== exp) begin
      failures++; $display("[TB] FAIL bp_next_grant: got %b expected %b", req_ready, exp);
    end
  endtask

  // Reset while a read is in flight: no response may ever appear, and the
  // pointer restarts at 0.
  task automatic test_mid_reset();
    int seen;
    logic [NR-1:0] exp;
    seen = 0;
    doReset();
    req_valid = 4'b0010;
    setAddr(1, 5'd7);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("[TB] FAIL mid_grant: got %b expected 0010", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    modelPtr = 0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || mux_select !== '0) begin
      failures++;
      $display("[TB] FAIL mid_reset_state: valid=%b sel=%0d expected valid=0 sel=0", resp_valid, mux_select);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("[TB] FAIL mid_dropped_resp: got %0d valid cycles expected 0", seen);
    end
    @(posedge clk);
    #1;
    req_valid = '1;
    @(negedge clk);
    exp = oneHot(pickWinner(req_valid, modelPtr));
    checks++;
    if (req_ready !== exp) begin
      failures++; $display("[TB] FAIL mid_ptr_restart: got %b expected %b", req_ready, exp);
    end
  endtask

  // An address change after the grant must not affect the returned data.
  task automatic test_addr_change();
    doReset();
    req_valid = 4'b0010;
    setAddr(1, 5'd5);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("[TB] FAIL addr_grant: got %b expected 0010", req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    setAddr(1, 5'd9);
    tick();
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== memData[5] || mux_select !== 5'd5 || resp_id !== 2'd1) begin
      failures++;
      $display("[TB] FAIL addr_captured: valid=%b data=%h sel=%0d id=%0d expected valid=1 data=%h sel=5 id=1",
               resp_valid, resp_data, mux_select, resp_id, memData[5]);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  // Random requests, withdrawals and backpressure, compared cycle by cycle
  // against the transaction model. A new grant is allowed from the cycle
  // after the previous handshake. The response appears two cycles after
  // its grant.
  task automatic test_random_traffic();
    logic [NR-1:0]     pend;
    logic [ADDR_W-1:0] pAddr [NR];
    logic [NR-1:0]     expReady;
    logic              expValid;
    logic              outstanding;
    int grantCyc;
    int nextGrant;
    int qId;
    int w;
    logic [ADDR_W-1:0] qAddr;
    pend        = '0;
    outstanding = 1'b0;
    grantCyc    = 0;
    nextGrant   = 0;
    qId         = 0;
    qAddr       = '0;
    for (int i = 0; i < NR; i++) pAddr[i] = '0;
    doReset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 30) begin
          pend[i]  = 1'b1;
          pAddr[i] = ADDR_W'($urandom_range(0, 31));
        end else if (pend[i] && $urandom_range(0, 99) < 5) begin
          pend[i] = 1'b0;
        end
        setAddr(i, pend[i] ? pAddr[i] : ADDR_W'($urandom_range(0, 31)));
      end
      req_valid  = pend;
      resp_ready = ($urandom_range(0, 99) < 60);
      @(negedge clk);
      expReady = '0;
      if (!outstanding && cyc >= nextGrant) expReady = oneHot(pickWinner(pend, modelPtr));
      checks++;
      if (req_ready !== expReady) begin
        failures++; $display("[TB] FAIL rand_grant cyc %0d: got %b expected %b", cyc, req_ready, expReady);
      end
      if (expReady != '0) begin
        w           = pickWinner(pend, modelPtr);
        outstanding = 1'b1;
        grantCyc    = cyc;
        qId         = w;
        qAddr       = pAddr[w];
        modelPtr    = (w + 1) % NR;
        pend[IW'(w)] = 1'b0;
      end
      expValid = outstanding && (cyc >= grantCyc + 2);
      checks++;
      if (resp_valid !== expValid) begin
        failures++; $display("[TB] FAIL rand_valid cyc %0d: got %b expected %b", cyc, resp_valid, expValid);
      end
      if (expValid) begin
        checks++;
        if (resp_data !== memData[qAddr] || resp_id !== IW'(qId) || mux_select !== qAddr) begin
          failures++;
          $display("[TB] FAIL rand_resp cyc %0d: data=%h id=%0d sel=%0d expected data=%h id=%0d sel=%0d",
                   cyc, resp_data, resp_id, mux_select, memData[qAddr], qId, qAddr);
        end
        if (resp_ready) begin
          outstanding = 1'b0;
          nextGrant   = cyc + 1;
        end
      end
      @(posedge clk);
      #1;
    end
    req_valid  = '0;
    resp_ready = 1'b0;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) memData[i] = $urandom;
    memData[17] = 32'hDEAD_0017;
    memData[9]  = ~memData[5];
    req_valid   = '0;
    req_addr    = '0;
    resp_ready  = 1'b0;
    rst         = 1'b1;

    test_reset();
    test_single_read();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    test_addr_change();
    test_random_traffic();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rf_read_arbiter
